// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and writeback request type for the register-file write arbiter
package rf_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  int best;
  int d;
  always_comb begin
    best = N;
    d = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best) begin
        best = d;
        idx = W'(i);
      end
    end
    gnt = best < N ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port; RF_WR_ARB_SCOREBOARD_EN adds a busy scoreboard
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter bit DROP_R0 = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [REG_ADDR_W-1:0]        writereg,
  output logic [DATA_W-1:0]            writedata,
  output logic                         regwrite
`ifdef RF_WR_ARB_SCOREBOARD_EN
  ,
  input  logic                         rsv_valid,
  input  logic [REG_ADDR_W-1:0]        rsv_reg,
  output logic [NUM_REGS-1:0]          busy_vec
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] idx;
  logic [NUM_REQ-1:0] gnt;
  wb_req_t win;
  logic hs;
  logic drop;
  rr_arbiter #(.N(NUM_REQ), .W(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx)
  );
  assign req_ready = reset ? '0 : gnt;
  assign hs = |req_ready;
  assign drop = DROP_R0 && win.addr == '0;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (idx == PW'(i))
        win = '{addr: req_reg[REG_ADDR_W*i +: REG_ADDR_W], data: req_data[DATA_W*i +: DATA_W]};
  end
  // A dropped r0 write completes the handshake but leaves the write port untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      regwrite <= 1'b0;
      writereg <= '0;
      writedata <= '0;
    end else begin
      regwrite <= hs && !drop;
      if (hs) rr_ptr <= idx == PW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
      if (hs && !drop) begin
        writereg <= win.addr;
        writedata <= win.data;
      end
    end
  end
`ifdef RF_WR_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  assign set_vec = (rsv_valid && !(DROP_R0 && rsv_reg == '0)) ? NUM_REGS'(1) << rsv_reg : '0;
  assign clr_vec = regwrite ? NUM_REGS'(1) << writereg : '0;
  // Set is applied after clear so a fresh reservation survives a same-cycle commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_vec <= '0;
    else busy_vec <= (busy_vec & ~clr_vec) | set_vec;
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and randomized checks against a search-based reference model
module tb_regfile_write_arbiter;
  localparam int N = 3;
  localparam bit DROP = 1;
  logic clock = 0;
  logic reset = 1;
  logic [N-1:0] req_valid = '0;
  logic [5*N-1:0] req_reg = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic [4:0] writereg;
  logic [31:0] writedata;
  logic regwrite;
`ifdef RF_WR_ARB_SCOREBOARD_EN
  logic rsv_valid = 0;
  logic [4:0] rsv_reg = '0;
  logic [31:0] busy_vec;
`endif
  int checks = 0;
  int failures = 0;
  int m_ptr;
  bit m_rw;
  logic [4:0] m_wreg;
  logic [31:0] m_wdata;

  regfile_write_arbiter #(.NUM_REQ(N), .DROP_R0(DROP)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_reg(req_reg),
    .req_data(req_data),
    .req_ready(req_ready),
    .writereg(writereg),
    .writedata(writedata),
    .regwrite(regwrite)
`ifdef RF_WR_ARB_SCOREBOARD_EN
    ,
    .rsv_valid(rsv_valid),
    .rsv_reg(rsv_reg),
    .busy_vec(busy_vec)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int exp_grant(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_rw = 0;
    m_wreg = '0;
    m_wdata = '0;
  endtask

  task automatic model_step();
    int g;
    g = exp_grant(req_valid, m_ptr);
    m_rw = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (!(DROP && req_reg[5*g +: 5] == 0)) begin
        m_rw = 1;
        m_wreg = req_reg[5*g +: 5];
        m_wdata = req_data[32*g +: 32];
      end
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] r, input logic [31:0] d);
    req_valid[i] = v;
    req_reg[5*i +: 5] = r;
    req_data[32*i +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = '1;
    #3;
    checks++; if (req_ready !== '0) $display("FAIL reset_ready got=%b exp=000", req_ready);
    checks++; if (regwrite !== 1'b0) $display("FAIL reset_regwrite got=%b exp=0", regwrite);
    checks++; if (writereg !== 5'd0 || writedata !== 32'd0) $display("FAIL reset_port got=%h/%h exp=0/0", writereg, writedata);
    if (req_ready !== '0) failures++;
    if (regwrite !== 1'b0) failures++;
    if (writereg !== 5'd0 || writedata !== 32'd0) failures++;
    @(negedge clock);
    req_valid = '0;
    reset = 0;
    model_reset();
    tick();
  endtask

  task automatic test_single();
    set_req(0, 1, 5'd5, 32'hDEADBEEF);
    @(negedge clock);
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    model_step();
    tick();
    set_req(0, 0, 5'd0, 32'd0);
    checks++; if (regwrite !== 1'b1) begin failures++; $display("FAIL single_regwrite got=%b exp=1", regwrite); end
    checks++; if (writereg !== 5'd5 || writedata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_port got=%h/%h exp=05/deadbeef", writereg, writedata); end
    @(negedge clock);
    model_step();
    tick();
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", regwrite); end
    checks++; if (writereg !== 5'd5 || writedata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%h/%h exp=05/deadbeef", writereg, writedata); end
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(10 + i), 32'hA0 + 32'(i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++; if (req_ready !== onehot(k % N)) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, req_ready, onehot(k % N)); end
      if (k > 0) begin
        checks++;
        if (regwrite !== 1'b1 || writereg !== 5'(10 + (k - 1) % N) || writedata !== 32'hA0 + 32'((k - 1) % N)) begin
          failures++;
          $display("FAIL fair_write%0d got=%b/%h/%h exp=1/%h/%h", k, regwrite, writereg, writedata, 5'(10 + (k - 1) % N), 32'hA0 + 32'((k - 1) % N));
        end
      end
      model_step();
      tick();
    end
    req_valid = '0;
    checks++; if (regwrite !== 1'b1 || writereg !== 5'd12 || writedata !== 32'hA2) begin failures++; $display("FAIL fair_last got=%b/%h/%h exp=1/0c/a2", regwrite, writereg, writedata); end
    @(negedge clock);
    model_step();
    tick();
  endtask

  task automatic test_two();
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    do_reset();
    set_req(1, 1, 5'd3, d1);
    set_req(2, 1, 5'd4, d2);
    @(negedge clock);
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL two_first got=%b exp=010", req_ready); end
    model_step();
    tick();
    set_req(1, 0, 5'd0, 32'd0);
    @(negedge clock);
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL two_second got=%b exp=100", req_ready); end
    checks++; if (regwrite !== 1'b1 || writereg !== 5'd3 || writedata !== d1) begin failures++; $display("FAIL two_w1 got=%b/%h/%h exp=1/03/%h", regwrite, writereg, writedata, d1); end
    model_step();
    tick();
    set_req(2, 0, 5'd0, 32'd0);
    checks++; if (regwrite !== 1'b1 || writereg !== 5'd4 || writedata !== d2) begin failures++; $display("FAIL two_w2 got=%b/%h/%h exp=1/04/%h", regwrite, writereg, writedata, d2); end
    @(negedge clock);
    model_step();
    tick();
  endtask

  task automatic test_drop_r0();
    do_reset();
    set_req(0, 1, 5'd0, 32'h1234);
    @(negedge clock);
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL drop_ready got=%b exp=001", req_ready); end
    model_step();
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(20 + i), 32'hB0 + 32'(i));
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL drop_regwrite got=%b exp=0", regwrite); end
    @(negedge clock);
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL drop_ptr got=%b exp=010", req_ready); end
    model_step();
    tick();
    req_valid = '0;
    checks++; if (regwrite !== 1'b1 || writereg !== 5'd21 || writedata !== 32'hB1) begin failures++; $display("FAIL drop_next got=%b/%h/%h exp=1/15/b1", regwrite, writereg, writedata); end
    @(negedge clock);
    model_step();
    tick();
  endtask

  task automatic test_reset_midstream();
    set_req(2, 1, 5'd9, 32'hCAFEF00D);
    @(negedge clock);
    checks++; if (req_ready !== onehot(exp_grant(req_valid, m_ptr))) begin failures++; $display("FAIL mid_ready got=%b exp=%b", req_ready, onehot(exp_grant(req_valid, m_ptr))); end
    model_step();
    tick();
    checks++; if (regwrite !== 1'b1 || writereg !== 5'd9) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/09", regwrite, writereg); end
    req_valid = '1;
    reset = 1;
    #1;
    checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL mid_regwrite got=%b exp=0", regwrite); end
    checks++; if (writereg !== 5'd0 || writedata !== 32'd0) begin failures++; $display("FAIL mid_port got=%h/%h exp=0/0", writereg, writedata); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL mid_ready_rst got=%b exp=000", req_ready); end
    req_valid = '0;
    #1;
    reset = 0;
    model_reset();
    @(negedge clock);
    checks++; if (req_ready !== '0 || regwrite !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b exp=000/0", req_ready, regwrite); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      checks++; if (req_ready !== onehot(exp_grant(req_valid, m_ptr))) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, onehot(exp_grant(req_valid, m_ptr))); end
      checks++; if (regwrite !== m_rw) begin failures++; $display("FAIL rand_regwrite c=%0d got=%b exp=%b", c, regwrite, m_rw); end
      checks++; if (writereg !== m_wreg || writedata !== m_wdata) begin failures++; $display("FAIL rand_port c=%0d got=%h/%h exp=%h/%h", c, writereg, writedata, m_wreg, m_wdata); end
      rdy = req_ready;
      model_step();
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || rdy[i]) begin
          if ($urandom_range(0, 2) != 0) set_req(i, 1, 5'($urandom_range(0, 31)), $urandom);
          else set_req(i, 0, 5'd0, 32'd0);
        end
    end
    req_valid = '0;
    @(negedge clock);
    model_step();
    tick();
  endtask

`ifdef RF_WR_ARB_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL sb_reset got=%h exp=0", busy_vec); end
    rsv_valid = 1;
    rsv_reg = 5'd7;
    tick();
    rsv_valid = 0;
    checks++; if (busy_vec[7] !== 1'b1) begin failures++; $display("FAIL sb_set got=%b exp=1", busy_vec[7]); end
    set_req(0, 1, 5'd7, 32'h77);
    tick();
    set_req(0, 0, 5'd0, 32'd0);
    rsv_valid = 1;
    rsv_reg = 5'd7;
    tick();
    rsv_valid = 0;
    checks++; if (busy_vec[7] !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%b exp=1", busy_vec[7]); end
    set_req(1, 1, 5'd7, 32'h78);
    tick();
    set_req(1, 0, 5'd0, 32'd0);
    tick();
    checks++; if (busy_vec[7] !== 1'b0) begin failures++; $display("FAIL sb_clear got=%b exp=0", busy_vec[7]); end
    rsv_valid = 1;
    rsv_reg = 5'd0;
    tick();
    rsv_valid = 0;
    checks++; if (busy_vec !== 32'd0) begin failures++; $display("FAIL sb_r0 got=%h exp=0", busy_vec); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_two();
    test_drop_r0();
    test_reset_midstream();
    test_random();
`ifdef RF_WR_ARB_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
